result_serializer: RTL and testbench

- Downstream of the paralellizer and the encrypter bank.
- Collects finished ENCRYPTER_WIDTH-bit result packets from the encrypters in strict round-robin order. This matches the order in which the paralellizer dispatched them, so the output stream preserves input order.
- Streams each packet out as 4-bit QSPI nibbles, most significant nibble first, using a valid/accept handshake toward the QSPI transmitter.

---
 rtl/result_serializer_pkg.sv | 15 +
 rtl/result_serializer_nibble_shift_out.sv | 50 +++++
 rtl/result_serializer.sv | 102 ++++++++++
 tb/tb_result_serializer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_serializer_pkg.sv
// rtl/result_serializer_pkg.sv - shared constants and serializer state type
package result_serializer_pkg;

  localparam int ENCRYPTER_WIDTH    = 32;
  localparam int NUM_ENCRYPTERS     = 4;
  localparam int NUM_ENCRYPTERS_REG = 2;
  localparam int NIBBLE_COUNT       = ENCRYPTER_WIDTH / 4;
  localparam int NIBBLE_COUNT_REG   = 3;

  typedef enum logic [1:0] {
    WAIT_RESULT = 2'd0,
    SEND        = 2'd1
  } ser_state_e;

endpackage

// File: rtl/result_serializer_nibble_shift_out.sv
// rtl/result_serializer_nibble_shift_out.sv - parallel-load shift register emitting MS nibble first
module result_serializer_nibble_shift_out
  import result_serializer_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        load,
  input  logic                        shift,
  input  logic [ENCRYPTER_WIDTH-1:0]  load_data,
  output logic [3:0]                  nibble,
  output logic [NIBBLE_COUNT_REG-1:0] nibble_idx,
  output logic                        last
);

  localparam logic [NIBBLE_COUNT_REG-1:0] LAST_IDX = NIBBLE_COUNT_REG'(NIBBLE_COUNT - 1);

  logic [ENCRYPTER_WIDTH-1:0]  shift_q, shift_d;
  logic [NIBBLE_COUNT_REG-1:0] nib_q, nib_d;

  assign last       = (nib_q == LAST_IDX);
  assign nibble     = shift_q[ENCRYPTER_WIDTH-1:ENCRYPTER_WIDTH-4];
  assign nibble_idx = nib_q;

  always_comb begin
    shift_d = shift_q;
    nib_d   = nib_q;
    if (clear) begin
      shift_d = '0;
      nib_d   = '0;
    end else if (load) begin
      shift_d = load_data;
      nib_d   = '0;
    end else if (shift) begin
      shift_d = {shift_q[ENCRYPTER_WIDTH-5:0], 4'b0000};
      nib_d   = last ? '0 : nib_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      nib_q   <= '0;
    end else begin
      shift_q <= shift_d;
      nib_q   <= nib_d;
    end
  end

endmodule

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - round-robin collector streaming encrypter results as QSPI nibbles
module result_serializer
  import result_serializer_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog,
  input  logic [ENCRYPTER_WIDTH-1:0]    encrypters_result [NUM_ENCRYPTERS],
  input  logic [NUM_ENCRYPTERS-1:0]     encrypters_result_valid,
  output logic [NUM_ENCRYPTERS-1:0]     encrypters_result_ack,
  output logic [3:0]                    qspi_data,
  output logic                          qspi_valid,
  input  logic                          qspi_accept,
  output logic [1:0]                    state_out,
  output logic [NUM_ENCRYPTERS_REG-1:0] encrypter_index_out,
  output logic [NIBBLE_COUNT_REG-1:0]   nibble_index_out
);

  localparam logic [NUM_ENCRYPTERS_REG-1:0] LAST_PORT = NUM_ENCRYPTERS_REG'(NUM_ENCRYPTERS - 1);

  ser_state_e                    state_q, state_d;
  logic [NUM_ENCRYPTERS_REG-1:0] index_q, index_d;
  logic [NUM_ENCRYPTERS-1:0]     ack_q, ack_d;
  logic                          valid_q, valid_d;
  logic                          sh_clear, sh_load, sh_shift, sh_last;

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    ack_d    = '0;
    valid_d  = valid_q;
    sh_clear = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    if (prog) begin
      state_d  = WAIT_RESULT;
      index_d  = '0;
      valid_d  = 1'b0;
      sh_clear = 1'b1;
    end else begin
      case (state_q)
        WAIT_RESULT: begin
          valid_d = 1'b0;
          // Only the port whose turn it is may be captured, keeping input order.
          if (encrypters_result_valid[index_q]) begin
            sh_load        = 1'b1;
            ack_d[index_q] = 1'b1;
            valid_d        = 1'b1;
            state_d        = SEND;
          end
        end
        SEND: begin
          valid_d = 1'b1;
          if (qspi_accept) begin
            sh_shift = 1'b1;
            if (sh_last) begin
              valid_d = 1'b0;
              index_d = (index_q == LAST_PORT) ? '0 : index_q + 1'b1;
              state_d = WAIT_RESULT;
            end
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = WAIT_RESULT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_RESULT;
      index_q <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
    end
  end

  result_serializer_nibble_shift_out u_shift (
    .clk        (clk),
    .reset      (reset),
    .clear      (sh_clear),
    .load       (sh_load),
    .shift      (sh_shift),
    .load_data  (encrypters_result[index_q]),
    .nibble     (qspi_data),
    .nibble_idx (nibble_index_out),
    .last       (sh_last)
  );

  assign encrypters_result_ack = ack_q;
  assign qspi_valid            = valid_q;
  assign state_out             = state_q;
  assign encrypter_index_out   = index_q;

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - scoreboard bench for result_serializer
module tb_result_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog;
  logic [31:0] res [4];
  logic [3:0]  rvalid;
  logic [3:0]  ack;
  logic [3:0]  qspi_data;
  logic        qspi_valid;
  logic        qspi_accept;
  logic [1:0]  state_out;
  logic [1:0]  idx_out;
  logic [2:0]  nib_out;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb [$];
  int ack_log [$];
  int ack_sb [$];
  int valid_cycles;
  bit prev_stall = 1'b0;
  logic [3:0] prev_data = '0;

  always #5 clk = ~clk;

  result_serializer dut (
    .clk                     (clk),
    .reset                   (reset),
    .prog                    (prog),
    .encrypters_result       (res),
    .encrypters_result_valid (rvalid),
    .encrypters_result_ack   (ack),
    .qspi_data               (qspi_data),
    .qspi_valid              (qspi_valid),
    .qspi_accept             (qspi_accept),
    .state_out               (state_out),
    .encrypter_index_out     (idx_out),
    .nibble_index_out        (nib_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_packet(input logic [31:0] d);
    for (int i = 7; i >= 0; i--) sb.push_back(d[4*i +: 4]);
  endtask

  // Transmitter side: every accepted nibble must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && !prog && prev_stall) begin
      chk("stall_hold_data", qspi_data, prev_data);
      chk("stall_hold_valid", qspi_valid, 1);
    end
    if (reset && !prog && qspi_valid && qspi_accept) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_nibble observed=%0h expected=none", qspi_data);
      end
      if (sb.size() > 0) chk("nibble", qspi_data, sb.pop_front());
    end
    prev_stall = reset && !prog && qspi_valid && !qspi_accept;
    prev_data  = qspi_data;
  end

  task automatic run_drain(input bit stall, input int max_cyc);
    bit done = 1'b0;
    int cyc  = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    ack_log.delete();
    ack_sb.delete();
    valid_cycles = 0;
    while (!done && cyc < max_cyc) begin
      qspi_accept = stall ? pat[cyc % 4] : 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          rvalid[i] = 1'b0;
          ack_log.push_back(i);
          ack_sb.push_back(sb.size());
        end
      end
      if (qspi_valid) valid_cycles++;
      if (sb.size() == 0 && !qspi_valid) done = 1'b1;
      cyc++;
    end
    qspi_accept = 1'b1;
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0 pending", sb.size());
    end
  endtask

  task automatic wait_sb_empty(input int max_cyc);
    int cyc = 0;
    while (sb.size() != 0 && cyc < max_cyc) begin
      tick();
      for (int i = 0; i < 4; i++) if (ack[i]) rvalid[i] = 1'b0;
      cyc++;
    end
    chk("wait_sb_empty", sb.size(), 0);
  endtask

  task automatic pulse_prog();
    prog = 1'b1;
    tick();
    prog = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    prog = 1'b0;
    rvalid = '0;
    qspi_accept = 1'b1;
    for (int i = 0; i < 4; i++) res[i] = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_valid", qspi_valid, 0);
    chk("rst_data", qspi_data, 0);
    chk("rst_ack", ack, 0);
    chk("rst_state", state_out, 0);
    chk("rst_index", idx_out, 0);
    chk("rst_nibble", nib_out, 0);

    // Single packet with accept tied high
    res[0] = 32'h1234ABCD;
    rvalid[0] = 1'b1;
    push_packet(32'h1234ABCD);
    run_drain(1'b0, 100);
    chk("single_ack_count", ack_log.size(), 1);
    chk("single_ack_port", ack_log[0], 0);
    chk("single_valid_cycles", valid_cycles, 8);
    chk("single_index_after", idx_out, 1);

    pulse_prog();
    chk("prog_index", idx_out, 0);
    chk("prog_state", state_out, 0);

    // Port 2 raised early must wait its turn
    res[2] = 32'hCCCCCCCC;
    rvalid[2] = 1'b1;
    repeat (3) tick();
    chk("order_no_early_ack", ack, 0);
    chk("order_idle_valid", qspi_valid, 0);
    res[0] = 32'hAAAAAAAA;
    res[1] = 32'hBBBBBBBB;
    rvalid[0] = 1'b1;
    rvalid[1] = 1'b1;
    push_packet(32'hAAAAAAAA);
    push_packet(32'hBBBBBBBB);
    push_packet(32'hCCCCCCCC);
    run_drain(1'b0, 200);
    chk("order_ack_count", ack_log.size(), 3);
    chk("order_ack0", ack_log[0], 0);
    chk("order_ack1", ack_log[1], 1);
    chk("order_ack2", ack_log[2], 2);
    chk("order_ack2_after_b", ack_sb[2], 8);
    chk("order_index_after", idx_out, 3);

    // Stalled packet on port 3
    res[3] = 32'hDEADBEEF;
    rvalid[3] = 1'b1;
    push_packet(32'hDEADBEEF);
    run_drain(1'b1, 200);
    chk("stall_ack_port", ack_log[0], 3);
    chk("stall_index_wrap", idx_out, 0);

    // Five packets across the wrap
    for (int k = 0; k < 5; k++) begin
      res[k % 4] = 32'(k + 1);
      rvalid[k % 4] = 1'b1;
      push_packet(32'(k + 1));
      run_drain(1'b0, 100);
      chk("wrap_ack_port", ack_log[0], k % 4);
      chk("wrap_index", idx_out, (k + 1) % 4);
    end

    // prog abort after three nibbles of a packet on port 1
    res[1] = 32'h87654321;
    rvalid[1] = 1'b1;
    sb.push_back(4'h8);
    sb.push_back(4'h7);
    sb.push_back(4'h6);
    wait_sb_empty(50);
    chk("abort_mid_nibble", nib_out, 3);
    pulse_prog();
    chk("abort_valid", qspi_valid, 0);
    chk("abort_index", idx_out, 0);
    chk("abort_nibble", nib_out, 0);
    res[0] = 32'h0F1E2D3C;
    rvalid[0] = 1'b1;
    push_packet(32'h0F1E2D3C);
    run_drain(1'b0, 100);
    chk("abort_next_port", ack_log[0], 0);
    chk("abort_next_count", ack_log.size(), 1);

    // Asynchronous reset in the middle of a packet
    res[1] = 32'h13579BDF;
    rvalid[1] = 1'b1;
    sb.push_back(4'h1);
    sb.push_back(4'h3);
    wait_sb_empty(50);
    #2 reset = 1'b0;
    #1;
    chk("amid_rst_valid", qspi_valid, 0);
    chk("amid_rst_state", state_out, 0);
    chk("amid_rst_data", qspi_data, 0);
    chk("amid_rst_index", idx_out, 0);
    sb.delete();
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("post_rst_valid", qspi_valid, 0);
    chk("post_rst_ack", ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
